// File: rtl/bit8_register_pkg.sv
// Shared constants and word type for the parallel-load storage register.
package bit8_register_pkg;

  localparam int REG_WIDTH = 8;
  localparam logic [REG_WIDTH-1:0] REG_RESET = 8'h00;

  typedef logic [REG_WIDTH-1:0] reg_word_t;

endpackage : bit8_register_pkg

// File: rtl/dff_sync_clr.sv
// Single-bit D flip-flop with synchronous active-low clear.
module dff_sync_clr (
  input  logic Clk,
  input  logic Clear,
  input  logic D,
  output logic Q
);

  always_ff @(posedge Clk) begin
    if (!Clear) Q <= 1'b0;
    else        Q <= D;
  end

endmodule : dff_sync_clr

// File: rtl/bit8_register.sv
// Parallel-load register built from one dff_sync_clr per bit.
// Define BIT8_REGISTER_ASSERT_EN to compile in simulation-only checkers.
module bit8_register
  import bit8_register_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] OUT
);

  // OUT comes straight from the flop outputs; no combinational path from IN or Clear.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_sync_clr u_dff (
      .Clk   (Clk),
      .Clear (Clear),
      .D     (IN[i]),
      .Q     (OUT[i])
    );
  end

`ifdef BIT8_REGISTER_ASSERT_EN
  a_clear_zeroes : assert property (@(posedge Clk) !Clear |=> (OUT == '0));

  a_load_tracks : assert property (@(posedge Clk)
    (Clear && !$isunknown(IN)) |=> (OUT == $past(IN)));

  a_clear_known : assert property (@(posedge Clk) !$isunknown(Clear));
`endif

endmodule : bit8_register

// File: tb/tb_bit8_register.sv
// Directed scoreboard bench for bit8_register with hand-derived expected values.
module tb_bit8_register;

  logic       Clk;
  logic       Clear;
  logic [7:0] IN;
  logic [7:0] OUT;

  bit8_register dut (
    .Clk   (Clk),
    .Clear (Clear),
    .IN    (IN),
    .OUT   (OUT)
  );

  logic [7:0] exp_q[$];
  string      name_q[$];
  event       check_ev;
  int         n_checks = 0;
  int         n_fail   = 0;

  // Monitor: whenever a sample point is announced, pop the expectation and compare.
  initial begin
    forever begin
      @(check_ev);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_sample: OUT=%h with no expected value queued", OUT);
      end else begin
        logic [7:0] e;
        string      nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_checks++;
        if (OUT !== e) begin
          n_fail++;
          $display("FAIL %s: OUT=%h expected=%h", nm, OUT, e);
        end
      end
    end
  end

  task automatic expect_out(input string nm, input logic [7:0] v);
    exp_q.push_back(v);
    name_q.push_back(nm);
    #1;
    ->check_ev;
    #1;
  endtask

  task automatic rise();
    Clk = 1'b1;
    #1;
  endtask

  task automatic fall();
    Clk = 1'b0;
    #4;
  endtask

  initial begin
    Clk   = 1'b0;
    Clear = 1'b0;
    IN    = 8'b1111_0110;
    #5;

    // Reset edge with nonzero data on IN.
    rise();
    expect_out("reset_edge", 8'h00);

    // Clk held high: Clear and IN change with no edge.
    Clear = 1'b1;
    IN    = 8'b0101_0101;
    #2;
    expect_out("no_edge_hold", 8'h00);

    // Reset wins over data at the next edge.
    Clear = 1'b0;
    fall();
    rise();
    expect_out("reset_wins", 8'h00);

    // Two consecutive loads.
    fall();
    Clear = 1'b1;
    IN    = 8'hA5;
    #1;
    rise();
    expect_out("load_a5", 8'hA5);
    fall();
    IN = 8'h3C;
    rise();
    expect_out("load_3c", 8'h3C);

    // Load FF, then a Clear pulse that never spans an edge.
    fall();
    IN = 8'hFF;
    rise();
    expect_out("load_ff", 8'hFF);
    fall();
    Clear = 1'b0;
    #2;
    Clear = 1'b1;
    #2;
    expect_out("clear_pulse_between_edges", 8'hFF);
    IN = 8'h5A;
    rise();
    expect_out("reload_after_pulse", 8'h5A);

    // Clear low across an edge, then immediate reload with no recovery cycle.
    fall();
    Clear = 1'b0;
    rise();
    expect_out("clear_across_edge", 8'h00);
    fall();
    Clear = 1'b1;
    IN    = 8'hC3;
    rise();
    expect_out("reload_after_reset", 8'hC3);

    // Walking one on consecutive edges.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'h01 << i;
      fall();
      IN = w;
      rise();
      expect_out($sformatf("walk_bit%0d", i), w);
    end

    // IN changing while Clk is high must not reach OUT.
    IN = 8'h00;
    #2;
    expect_out("in_change_no_edge", 8'h80);
    fall();

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bit8_register
